// File: rtl/baccarat_deal_fsm.sv
// Baccarat dealer: requests cards, deals P1,B1,P2,B2, applies the third-card rules and flags the winner.
// Optional per-card wait limit (ERR state, timeout flag) is built when CARD_TIMEOUT_EN is defined.
module baccarat_deal_fsm #(
  parameter int N        = 4,
  parameter int CARD_MAX = 13,
  parameter int TIMEOUT  = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         card_valid,
  input  logic [N-1:0] card_in,
  output logic         card_req,
  output logic [N-1:0] pcard1,
  output logic [N-1:0] pcard2,
  output logic [N-1:0] pcard3,
  output logic [N-1:0] bcard1,
  output logic [N-1:0] bcard2,
  output logic [N-1:0] bcard3,
  output logic [N-1:0] pscore,
  output logic [N-1:0] bscore,
  output logic         player_win,
  output logic         banker_win,
  output logic         tie,
  output logic         done,
  output logic         bad_card,
  output logic         timeout
);

  typedef enum logic [3:0] {
    IDLE, DEAL_P1, DEAL_B1, DEAL_P2, DEAL_B2, CHECK,
    DEAL_P3, BANK_DECIDE, DEAL_B3, DONE, ERR
  } state_t;

  state_t       state_reg;
  logic [N-1:0] pcard1_reg, pcard2_reg, pcard3_reg;
  logic [N-1:0] bcard1_reg, bcard2_reg, bcard3_reg;
  logic         player_win_reg, banker_win_reg, tie_reg;
  logic         done_reg, bad_card_reg;

  logic         card_legal, card_take;
  logic         natural, bank_draw, goto_done, wait_expired;
  logic [N-1:0] final_bscore;

  // Face cards and tens count zero; empty slots (0) also count zero.
  function automatic logic [N:0] card_val(input logic [N-1:0] c);
    return (c >= N'(10)) ? '0 : {1'b0, c};
  endfunction

  function automatic logic [N-1:0] hand_score(input logic [N-1:0] c1, input logic [N-1:0] c2,
                                              input logic [N-1:0] c3);
    logic [N:0] sum;
    sum = card_val(c1) + card_val(c2) + card_val(c3);
    return N'(sum % (N+1)'(10));
  endfunction

  // Banker tableau: depends on whether the player drew and on the value of that third card.
  function automatic logic bank_draws(input logic [N-1:0] p3, input logic [N-1:0] bs);
    int t;
    t = int'(card_val(p3));
    if (p3 == '0) return (bs <= N'(5));
    case (int'(bs))
      0, 1, 2: return 1'b1;
      3:       return (t != 8);
      4:       return (t >= 2 && t <= 7);
      5:       return (t >= 4 && t <= 7);
      6:       return (t >= 6 && t <= 7);
      default: return 1'b0;
    endcase
  endfunction

  assign pscore     = hand_score(pcard1_reg, pcard2_reg, pcard3_reg);
  assign bscore     = hand_score(bcard1_reg, bcard2_reg, bcard3_reg);
  assign card_req   = state_reg inside {DEAL_P1, DEAL_B1, DEAL_P2, DEAL_B2, DEAL_P3, DEAL_B3};
  assign card_legal = (card_in != '0) && (card_in <= N'(CARD_MAX));
  assign card_take  = card_req && card_valid && card_legal;
  assign natural    = (pscore >= N'(8)) || (bscore >= N'(8));
  assign bank_draw  = bank_draws(pcard3_reg, bscore);

  // The banker's third card lands on the same edge the result is latched, so score it from card_in.
  assign final_bscore = (state_reg == DEAL_B3) ? hand_score(bcard1_reg, bcard2_reg, card_in) : bscore;
  assign goto_done    = ((state_reg == CHECK) && natural) ||
                        ((state_reg == BANK_DECIDE) && !bank_draw) ||
                        ((state_reg == DEAL_B3) && card_take);

`ifdef CARD_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] wait_cnt_reg;
  logic          timeout_reg;

  // Cleared outside DEAL_* and on every acceptance, so each card starts its wait from zero.
  always_ff @(posedge clock) begin
    if (reset || !card_req || card_take) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign wait_expired = card_req && !card_take && (wait_cnt_reg == TW'(TIMEOUT - 1));
  assign timeout      = timeout_reg;
`else
  assign wait_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      pcard1_reg     <= '0;
      pcard2_reg     <= '0;
      pcard3_reg     <= '0;
      bcard1_reg     <= '0;
      bcard2_reg     <= '0;
      bcard3_reg     <= '0;
      player_win_reg <= 1'b0;
      banker_win_reg <= 1'b0;
      tie_reg        <= 1'b0;
      done_reg       <= 1'b0;
      bad_card_reg   <= 1'b0;
`ifdef CARD_TIMEOUT_EN
      timeout_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_reg      <= DEAL_P1;
            pcard1_reg     <= '0;
            pcard2_reg     <= '0;
            pcard3_reg     <= '0;
            bcard1_reg     <= '0;
            bcard2_reg     <= '0;
            bcard3_reg     <= '0;
            player_win_reg <= 1'b0;
            banker_win_reg <= 1'b0;
            tie_reg        <= 1'b0;
            done_reg       <= 1'b0;
            bad_card_reg   <= 1'b0;
`ifdef CARD_TIMEOUT_EN
            timeout_reg    <= 1'b0;
`endif
          end
        end
        DEAL_P1: if (card_take) begin pcard1_reg <= card_in; state_reg <= DEAL_B1; end
        DEAL_B1: if (card_take) begin bcard1_reg <= card_in; state_reg <= DEAL_P2; end
        DEAL_P2: if (card_take) begin pcard2_reg <= card_in; state_reg <= DEAL_B2; end
        DEAL_B2: if (card_take) begin bcard2_reg <= card_in; state_reg <= CHECK;   end
        CHECK: begin
          if (natural)                 state_reg <= DONE;
          else if (pscore <= N'(5))    state_reg <= DEAL_P3;
          else                         state_reg <= BANK_DECIDE;
        end
        DEAL_P3: if (card_take) begin pcard3_reg <= card_in; state_reg <= BANK_DECIDE; end
        BANK_DECIDE: state_reg <= bank_draw ? DEAL_B3 : DONE;
        DEAL_B3: if (card_take) begin bcard3_reg <= card_in; state_reg <= DONE; end
        default: state_reg <= IDLE;
      endcase

      if (card_req && card_valid && !card_legal) begin
        bad_card_reg <= 1'b1;
      end

      if (wait_expired) begin
        state_reg   <= ERR;
`ifdef CARD_TIMEOUT_EN
        timeout_reg <= 1'b1;
`endif
      end

      if (goto_done) begin
        done_reg       <= 1'b1;
        player_win_reg <= (pscore > final_bscore);
        banker_win_reg <= (pscore < final_bscore);
        tie_reg        <= (pscore == final_bscore);
      end
    end
  end

  assign pcard1     = pcard1_reg;
  assign pcard2     = pcard2_reg;
  assign pcard3     = pcard3_reg;
  assign bcard1     = bcard1_reg;
  assign bcard2     = bcard2_reg;
  assign bcard3     = bcard3_reg;
  assign player_win = player_win_reg;
  assign banker_win = banker_win_reg;
  assign tie        = tie_reg;
  assign done       = done_reg;
  assign bad_card   = bad_card_reg;

endmodule

// File: tb/tb_baccarat_deal_fsm.sv
// Directed bench for baccarat_deal_fsm: table of complete rounds plus hand-written bad-card,
// reset, start-ignore and card-wait sequences.
module tb_baccarat_deal_fsm;
  localparam int N = 4;
`ifdef CARD_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic         clock = 1'b0;
  logic         reset, start, card_valid;
  logic [N-1:0] card_in;
  logic         card_req;
  logic [N-1:0] pcard1, pcard2, pcard3, bcard1, bcard2, bcard3, pscore, bscore;
  logic         player_win, banker_win, tie, done, bad_card, timeout;
  logic [38:0]  all_out;

  baccarat_deal_fsm #(.N(N), .CARD_MAX(13), .TIMEOUT(TB_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .card_valid(card_valid), .card_in(card_in),
    .card_req(card_req), .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .bcard1(bcard1), .bcard2(bcard2), .bcard3(bcard3), .pscore(pscore), .bscore(bscore),
    .player_win(player_win), .banker_win(banker_win), .tie(tie), .done(done),
    .bad_card(bad_card), .timeout(timeout)
  );

  always #5 clock = ~clock;

  assign all_out = {card_req, pcard1, pcard2, pcard3, bcard1, bcard2, bcard3, pscore, bscore,
                    player_win, banker_win, tie, done, bad_card, timeout};

  // cards: card k in bits [4k+3:4k]; flags = {player_win, banker_win, tie}; edges 0 = latency unchecked
  typedef struct {
    logic [23:0] cards;
    int          n;
    logic [3:0]  p3, b3, ps, bs;
    logic [2:0]  flags;
    int          edges;
  } vec_t;

  vec_t vecs [9];
  int   vectors = 0;
  int   miscompares = 0;
  int   used, edges;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic start_round();
    @(negedge clock); start = 1'b1; card_valid = 1'b0; card_in = '0;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
  endtask

  // Supplies the next card whenever the dealer asks; stops at done or after a cycle budget.
  task automatic feed_cards(input logic [23:0] cards, input int n, output int nused, output int nedges);
    bit drove;
    nused = 0;
    nedges = 0;
    while (!done && nedges < 40) begin
      if (card_req && nused < n) begin
        card_valid = 1'b1; card_in = cards[nused*4 +: 4]; drove = 1'b1;
      end else begin
        card_valid = 1'b0; card_in = '0; drove = 1'b0;
      end
      @(posedge clock);
      nedges++;
      if (drove) nused++;
      @(negedge clock);
    end
    card_valid = 1'b0;
    card_in = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; card_valid = 1'b0; card_in = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", 64'(all_out), 64'(0));
    reset = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("idle_no_req", 64'(card_req), 64'(0));

    vecs[0] = '{24'h003424, 4, 4'd0, 4'd0,  4'd8, 4'd5, 3'b100, 6};
    vecs[1] = '{24'hD75312, 6, 4'd7, 4'd13, 4'd2, 4'd6, 3'b010, 0};
    vecs[2] = '{24'h04261A, 5, 4'd0, 4'd4,  4'd6, 4'd7, 3'b010, 0};
    vecs[3] = '{24'h082111, 5, 4'd8, 4'd0,  4'd0, 4'd3, 3'b010, 0};
    vecs[4] = '{24'h003136, 4, 4'd0, 4'd0,  4'd7, 4'd6, 3'b100, 0};
    vecs[5] = '{24'h325555, 6, 4'd2, 4'd3,  4'd2, 4'd3, 3'b010, 0};
    vecs[6] = '{24'h009191, 4, 4'd0, 4'd0,  4'd2, 4'd8, 3'b010, 6};
    vecs[7] = '{24'h012222, 5, 4'd1, 4'd0,  4'd5, 4'd4, 3'b100, 0};
    vecs[8] = '{24'h005434, 4, 4'd0, 4'd0,  4'd8, 4'd8, 3'b001, 6};

    for (int i = 0; i < 9; i++) begin
      start_round();
      feed_cards(vecs[i].cards, vecs[i].n, used, edges);
      chk($sformatf("v%0d_done", i),  64'(done), 64'(1));
      chk($sformatf("v%0d_used", i),  64'(used), 64'(vecs[i].n));
      chk($sformatf("v%0d_req", i),   64'(card_req), 64'(0));
      chk($sformatf("v%0d_p3", i),    64'(pcard3), 64'(vecs[i].p3));
      chk($sformatf("v%0d_b3", i),    64'(bcard3), 64'(vecs[i].b3));
      chk($sformatf("v%0d_ps", i),    64'(pscore), 64'(vecs[i].ps));
      chk($sformatf("v%0d_bs", i),    64'(bscore), 64'(vecs[i].bs));
      chk($sformatf("v%0d_flags", i), 64'({player_win, banker_win, tie}), 64'(vecs[i].flags));
      if (vecs[i].edges != 0)
        chk($sformatf("v%0d_latency", i), 64'(edges + 1), 64'(vecs[i].edges));
      $display("round %0d: cards %h -> p3=%0d b3=%0d p=%0d b=%0d pw/bw/tie=%b edges=%0d",
               i, vecs[i].cards, pcard3, bcard3, pscore, bscore, {player_win, banker_win, tie}, edges + 1);
    end

    // Illegal cards in DEAL_P1 are refused and remembered for the round.
    start_round();
    card_valid = 1'b1; card_in = 4'd14;
    @(posedge clock); @(negedge clock);
    chk("bad14_flag", 64'(bad_card), 64'(1));
    chk("bad14_slot", 64'(pcard1), 64'(0));
    chk("bad14_hold", 64'(card_req), 64'(1));
    card_in = 4'd0;
    @(posedge clock); @(negedge clock);
    chk("bad0_slot", 64'(pcard1), 64'(0));
    chk("bad0_hold", 64'(card_req), 64'(1));
    feed_cards(24'h004433, 4, used, edges);
    chk("bad_round_done", 64'(done), 64'(1));
    chk("bad_round_tie", 64'({player_win, banker_win, tie}), 64'(3'b001));
    chk("bad_round_ps", 64'(pscore), 64'(7));
    chk("bad_sticky", 64'(bad_card), 64'(1));
    $display("bad-card round: p=%0d b=%0d tie=%0d bad_card=%0d", pscore, bscore, tie, bad_card);
    start_round();
    chk("bad_cleared", 64'(bad_card), 64'(0));
    chk("slots_cleared", 64'({pcard1, bcard1, done}), 64'(0));

    // Reset after B1 is accepted abandons the round.
    card_valid = 1'b1; card_in = 4'd5;
    @(posedge clock); @(negedge clock);
    card_in = 4'd6;
    @(posedge clock); @(negedge clock);
    card_valid = 1'b0;
    chk("mid_p1b1", 64'({pcard1, bcard1}), 64'({4'd5, 4'd6}));
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("mid_reset_outputs", 64'(all_out), 64'(0));
    reset = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("mid_reset_idle", 64'(card_req), 64'(0));
    $display("mid-deal reset: outputs=%h", all_out);

    // start while dealing is ignored.
    start_round();
    card_valid = 1'b1; card_in = 4'd7;
    @(posedge clock); @(negedge clock);
    card_valid = 1'b0; start = 1'b1;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    chk("start_ignored_slot", 64'(pcard1), 64'(7));
    chk("start_ignored_req", 64'(card_req), 64'(1));
    $display("start during deal: pcard1=%0d card_req=%0d", pcard1, card_req);

    // Card wait with valid low.
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    start_round();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("wait3_timeout", 64'(timeout), 64'(0));
    chk("wait3_req", 64'(card_req), 64'(1));
    @(posedge clock); @(negedge clock);
`ifdef CARD_TIMEOUT_EN
    chk("wait4_timeout", 64'(timeout), 64'(1));
    chk("wait4_err", 64'({card_req, done, player_win, banker_win, tie}), 64'(0));
    start_round();
    chk("err_exit_timeout", 64'(timeout), 64'(0));
    chk("err_exit_req", 64'(card_req), 64'(1));
`else
    repeat (20) @(posedge clock);
    @(negedge clock);
    chk("wait_long_timeout", 64'(timeout), 64'(0));
    chk("wait_long_req", 64'(card_req), 64'(1));
`endif
    $display("card wait: timeout=%0d card_req=%0d", timeout, card_req);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
